// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One result bit per cycle: shift-add multiply, restoring divide, then a sign-fix cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_e;

    state_e             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic               qsign_q, qsign_d;
    logic               rsign_q, rsign_d;
    logic               zdiv_q, zdiv_d;
    logic               dbz_flag_q, dbz_flag_d;
    logic               done_q, done_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    // op[1] selects divide, op[0] selects signed.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    assign a_neg = op[0] & a[WIDTH-1];
    assign b_neg = op[0] & b[WIDTH-1];
    assign a_abs = a_neg ? -a : a;
    assign b_abs = b_neg ? -b : b;

    // Multiply: acc = {partial product, unconsumed multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    logic [WIDTH:0]     rem_shift, trial;
    logic [2*WIDTH-1:0] div_next;
    assign rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign trial     = rem_shift - {1'b0, opnd_q};
    assign div_next  = trial[WIDTH] ? {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {trial[WIDTH-1:0],     acc_q[WIDTH-2:0], 1'b1};

    logic [WIDTH-1:0]   quo, rem;
    logic [2*WIDTH-1:0] prod;
    assign quo  = acc_q[WIDTH-1:0];
    assign rem  = acc_q[2*WIDTH-1:WIDTH];
    assign prod = qsign_q ? -acc_q : acc_q;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        is_div_d   = is_div_q;
        qsign_d    = qsign_q;
        rsign_d    = rsign_q;
        zdiv_d     = zdiv_q;
        dbz_flag_d = dbz_flag_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_div_d = op[1];
                    qsign_d  = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                    rsign_d  = a_neg;
                    zdiv_d   = op[1] & (b == '0);
                    cnt_d    = '0;
                    acc_d    = {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
                    opnd_d   = op[1] ? b_abs : a_abs;
                    if (op[1]) dbz_flag_d = 1'b0;
                    state_d  = S_RUN;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    // A zero divisor leaves the raw dividend as remainder; quotient is forced to all ones.
                    lo_d       = zdiv_q ? '1 : (qsign_q ? -quo : quo);
                    hi_d       = rsign_q ? -rem : rem;
                    dbz_flag_d = zdiv_q;
                end else begin
                    {hi_d, lo_d} = prod;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            is_div_q   <= 1'b0;
            qsign_q    <= 1'b0;
            rsign_q    <= 1'b0;
            zdiv_q     <= 1'b0;
            dbz_flag_q <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            is_div_q   <= is_div_d;
            qsign_q    <= qsign_d;
            rsign_q    <= rsign_d;
            zdiv_q     <= zdiv_d;
            dbz_flag_q <= dbz_flag_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_flag_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected HI/LO/flag, monitors pop on done.
module tb_mul_div_unit;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;
    localparam int         LIMIT    = 100;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
    } exp8_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    logic        start8 = 1'b0;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  a8 = '0, b8 = '0, wdata8 = '0;
    logic        busy8, done8, dbz8;
    logic [7:0]  hi8, lo8;

    exp_t        sb_q[$];
    exp8_t       sb8_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] model_hi = '0, model_lo = '0;
    logic        model_dbz = 1'b0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    mul_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .hi_we(1'b0), .lo_we(1'b0), .wdata(wdata8),
        .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL spurious_done: done with no pending operation (hi=%h lo=%h)", hi, lo);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result_hi", hi, e.hi);
                check("result_lo", lo, e.lo);
                check("result_dbz", div_by_zero, e.dbz);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done8) begin
            if (sb8_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL spurious_done8: done with no pending operation (hi=%h lo=%h)", hi8, lo8);
            end else begin
                exp8_t e;
                e = sb8_q.pop_front();
                check("w8_hi", hi8, e.hi);
                check("w8_lo", lo8, e.lo);
            end
        end
    end

    // mid: 0 nothing, 1 extra start while busy, 2 MTHI while busy.
    task automatic issue(input string name, input logic [1:0] op_v, input logic [31:0] a_v,
                         input logic [31:0] b_v, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic exp_dbz, input int mid, input logic same_hi_we);
        int cyc;
        int busy_cyc;
        exp_t e;
        @(negedge clk);
        start = 1'b1; op = op_v; a = a_v; b = b_v;
        hi_we = same_hi_we; wdata = 32'hDEADBEEF;
        e.hi = exp_hi; e.lo = exp_lo; e.dbz = exp_dbz;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        op = ~op_v; a = ~a_v; b = ~b_v;
        cyc = 0;
        busy_cyc = 0;
        while (!done && cyc < LIMIT) begin
            if (busy) busy_cyc++;
            if (cyc == 5 && mid == 1) begin start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7; end
            if (cyc == 5 && mid == 2) begin hi_we = 1'b1; wdata = 32'h0000FFFF; end
            if (cyc == 6) begin start = 1'b0; hi_we = 1'b0; end
            if (cyc == 10) begin
                check({name, "_hold_hi"}, hi, model_hi);
                check({name, "_hold_lo"}, lo, model_lo);
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= LIMIT) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s_timeout: no done after %0d cycles, expected within %0d", name, cyc, LIMIT);
        end
        check({name, "_busy_cycles"}, busy_cyc, 33);
        model_hi = exp_hi; model_lo = exp_lo; model_dbz = exp_dbz;
        @(negedge clk);
        check({name, "_done_pulse"}, {done, busy}, 2'b00);
        if (mid == 1) begin
            repeat (3) @(negedge clk);
            check({name, "_no_queue"}, busy, 1'b0);
        end
    endtask

    task automatic mt(input string name, input logic hw, input logic lw, input logic [31:0] data);
        @(negedge clk);
        hi_we = hw; lo_we = lw; wdata = data;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        if (hw) model_hi = data;
        if (lw) model_lo = data;
        check({name, "_hi"}, hi, model_hi);
        check({name, "_lo"}, lo, model_lo);
    endtask

    task automatic issue8(input string name, input logic [1:0] op_v, input logic [7:0] a_v,
                          input logic [7:0] b_v, input logic [7:0] exp_hi, input logic [7:0] exp_lo);
        int cyc;
        int busy_cyc;
        exp8_t e;
        @(negedge clk);
        start8 = 1'b1; op8 = op_v; a8 = a_v; b8 = b_v;
        e.hi = exp_hi; e.lo = exp_lo;
        sb8_q.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        cyc = 0;
        busy_cyc = 0;
        while (!done8 && cyc < LIMIT) begin
            if (busy8) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= LIMIT) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s_timeout: no done after %0d cycles, expected within %0d", name, cyc, LIMIT);
        end
        check({name, "_busy_cycles"}, busy_cyc, 9);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_state", {busy, done, div_by_zero, hi, lo}, 67'd0);
        rst = 1'b0;
        @(negedge clk);

        issue("multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0, 1'b0);
        issue("mult_neg",   OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0, 1'b0);
        issue("mult_minsq", OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 0, 1'b0);
        issue("div_neg",    OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0, 1'b0);
        issue("divu_100_7", OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 0, 1'b0);
        issue("div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0, 1'b0);
        issue("divu_zero",  OP_DIVU,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b1, 0, 1'b0);
        issue("mul_keeps_dbz", OP_MULTU, 32'd3,     32'd5,        32'd0,        32'd15,       1'b1, 1, 1'b0);
        issue("divu_10_3",  OP_DIVU,  32'd10,       32'd3,        32'd1,        32'd3,        1'b0, 0, 1'b0);

        mt("mtlo", 1'b0, 1'b1, 32'hCAFEBABE);
        mt("mthi", 1'b1, 1'b0, 32'h0BADF00D);
        mt("mt_both", 1'b1, 1'b1, 32'h55AA33CC);

        issue("mthi_busy",  OP_MULTU, 32'd6,        32'd7,        32'd0,        32'd42,       1'b0, 2, 1'b0);
        issue("start_mthi", OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 0, 1'b1);
        issue("div_zero_s", OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 0, 1'b0);

        // Abort a MULT mid-run with an asynchronous reset between clock edges.
        @(negedge clk);
        start = 1'b1; op = OP_MULT; a = 32'hFFFFFFFD; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset", {busy, done, div_by_zero, hi, lo}, 67'd0);
        @(negedge clk);
        rst = 1'b0;
        model_hi = '0; model_lo = '0; model_dbz = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_idle", busy, 1'b0);
        issue("after_reset", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 0, 1'b0);

        issue8("w8_mult", OP_MULT, 8'h80, 8'h80, 8'h40, 8'h00);
        issue8("w8_ovf",  OP_DIV,  8'h80, 8'hFF, 8'h00, 8'h80);

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        check("sb8_drained", sb8_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
